fnd_scan_controller: RTL and testbench

- Time-multiplexed scan sequencer for the 4-digit FND (7-segment) display.
- Generates the 3-bit digit position that drives the digit-select decoder and the segment-data mux.
- Position bit 2 selects the display page: 0 = digits 0-3 (HH:MM), 1 = digits 4-7 (SS:cc).
- Also owns the per-digit blink timing and anti-ghosting guard blanking, and emits a blank flag that feeds the decoder's on/off input.

---
 rtl/fnd_pkg.sv | 25 ++
 rtl/fnd_scan_controller_if.sv | 34 +++
 rtl/fnd_scan_controller_tick_divider.sv | 46 ++++
 rtl/fnd_scan_controller.sv | 91 +++++++++
 tb/tb_fnd_scan_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, page encoding and divisor helpers for the FND scan controller
// Purpose: common definitions imported by the scan controller, its interface and tick_divider.
// Ports: none (package).
package fnd_pkg;

  localparam int DIGITS = 4;
  localparam int POS_W  = 3;
  localparam int SLOT_W = $clog2(DIGITS);

  typedef enum logic {
    PAGE_HM = 1'b0,
    PAGE_SC = 1'b1
  } page_e;

  // Integer divisor used to derive slot and blink periods from the Hz parameters.
  function automatic int div_floor(input int num, input int den);
    return num / den;
  endfunction

  // Counter width for a modulo-n counter; never narrower than one bit so n = 1 stays legal.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// rtl/fnd_scan_controller_if.sv - control/status bundle between the FND scan controller and its user
// Purpose: groups the display-control inputs and scan outputs of fnd_scan_controller.
// Ports (members):
//   i_OnOffSW        1 = display off
//   i_page           requested page
//   i_blinkEn        global blink enable
//   i_blinkMask[3:0] per-slot blink select
//   o_digitPosition  {page, slot}
//   o_blank          1 = all digits off
//   o_scanTick       one-clock pulse per slot advance
//   o_blinkPhase     1 = visible half of the blink period
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic              i_OnOffSW;
  logic              i_page;
  logic              i_blinkEn;
  logic [DIGITS-1:0] i_blinkMask;
  logic [POS_W-1:0]  o_digitPosition;
  logic              o_blank;
  logic              o_scanTick;
  logic              o_blinkPhase;

  modport master (
    output i_OnOffSW, i_page, i_blinkEn, i_blinkMask,
    input  o_digitPosition, o_blank, o_scanTick, o_blinkPhase
  );

  modport slave (
    input  i_OnOffSW, i_page, i_blinkEn, i_blinkMask,
    output o_digitPosition, o_blank, o_scanTick, o_blinkPhase
  );

endinterface

// File: rtl/fnd_scan_controller_tick_divider.sv
// rtl/fnd_scan_controller_tick_divider.sv - enabled modulo-N counter with registered terminal flag
// Purpose: counts enabled clocks 0 .. N-1 and wraps; o_last is a flop that is 1 exactly while
//          the count sits at N-1, so with i_en tied high it is a clean one-clock terminal pulse.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_en            count enable
//   o_last          registered "count == N-1"
module tick_divider
  import fnd_pkg::*;
#(
  parameter int N = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_last
);

  localparam int              W    = cnt_w(N);
  localparam logic [W-1:0]    LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;
  logic         last_q, last_d;

  always_comb begin
    count_d = count_q;
    if (i_en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
    // Decoded from the next count so the flag lines up with the count register.
    last_d = (count_d == LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      last_q  <= (N == 1);
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign o_last = last_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - time-multiplexed scan sequencer for the 8-position FND display
// Purpose: steps the 4 digit slots, latches the page per frame, and produces blink phase,
//          slot-start guard blanking and the combined blank flag for the digit decoder.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      fnd_scan_controller_if.slave (control inputs, position/blank/tick/phase outputs)
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_HZ     = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fnd_scan_controller_if.slave  bus
);

  localparam int SCAN_DIV  = div_floor(CLK_HZ, SCAN_HZ);
  localparam int BLINK_DIV = div_floor(SCAN_HZ, 2 * BLINK_HZ);
  localparam int GUARD_W   = cnt_w(GUARD_CYCLES + 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGITS - 1);

  logic scan_tick;
  logic blink_last;
  logic blink_wrap;

  logic [SLOT_W-1:0]  slot_q,  slot_d;
  page_e              page_q,  page_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               phase_q, phase_d;

  // Scan prescaler: its terminal flag is the registered scan tick, and the slot advances on
  // the edge that ends that tick, which is the same edge the prescaler wraps.
  tick_divider #(.N(SCAN_DIV)) u_scan_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (1'b1),
    .o_last  (scan_tick)
  );

  // Blink counter counts slot ticks; it runs regardless of i_blinkEn to keep phase coherent.
  tick_divider #(.N(BLINK_DIV)) u_blink_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (scan_tick),
    .o_last  (blink_last)
  );

  assign blink_wrap = scan_tick & blink_last;

  always_comb begin
    slot_d  = slot_q;
    page_d  = page_q;
    guard_d = (guard_q != '0) ? guard_q - GUARD_W'(1) : '0;
    phase_d = blink_wrap ? ~phase_q : phase_q;
    if (scan_tick) begin
      slot_d  = slot_q + SLOT_W'(1);
      guard_d = GUARD_LOAD;
      // Page only changes at frame end so a frame is never split across pages.
      if (slot_q == SLOT_LAST) begin
        page_d = page_e'(bus.i_page);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_q  <= '0;
      page_q  <= PAGE_HM;
      guard_q <= GUARD_LOAD;
      phase_q <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      page_q  <= page_d;
      guard_q <= guard_d;
      phase_q <= phase_d;
    end
  end

  assign bus.o_digitPosition = {page_q, slot_q};
  assign bus.o_scanTick      = scan_tick;
  assign bus.o_blinkPhase    = phase_q;
  assign bus.o_blank         = bus.i_OnOffSW
                             | (guard_q != '0)
                             | (bus.i_blinkEn & ~phase_q & bus.i_blinkMask[slot_q]);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - self-checking bench for fnd_scan_controller
module tb_fnd_scan_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic onoff = 1'b0;
  logic page = 1'b0;
  logic blink_en = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic page2 = 1'b0;
  logic [3:0] mask2 = 4'b0000;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fnd_scan_controller_if bus1();
  fnd_scan_controller_if bus2();

  assign bus1.i_OnOffSW   = onoff;
  assign bus1.i_page      = page;
  assign bus1.i_blinkEn   = blink_en;
  assign bus1.i_blinkMask = mask;
  assign bus2.i_OnOffSW   = 1'b0;
  assign bus2.i_page      = page2;
  assign bus2.i_blinkEn   = 1'b0;
  assign bus2.i_blinkMask = mask2;

  fnd_scan_controller #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1), .GUARD_CYCLES(1)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus1.slave)
  );

  fnd_scan_controller #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1), .GUARD_CYCLES(0)) dut_ng (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus2.slave)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from the number of clocks since reset (mn).
  // SCAN_DIV = 4 clocks per slot, BLINK_DIV = 2 slots per half blink period, 16 clocks per frame.
  int   mn = 0;
  logic mpage = 1'b0;
  bit   mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mn = 0;
      mpage = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      mn++;
      if (mn % 16 == 0) mpage = page;
    end
  end

  always @(posedge clk) begin
    int k;
    int slot;
    logic ph;
    logic gd;
    logic exp_blank;
    #4;
    if (mvalid) begin
      k    = mn / 4;
      slot = k % 4;
      ph   = ((k / 2) % 2) == 0;
      gd   = (mn % 4) < 1;
      exp_blank = onoff | gd | (blink_en & ~ph & mask[slot]);
      chk("mon_pos",   8'(bus1.o_digitPosition), 8'({mpage, 2'(slot)}));
      chk("mon_tick",  8'(bus1.o_scanTick),      8'((mn % 4) == 3));
      chk("mon_phase", 8'(bus1.o_blinkPhase),    8'(ph));
      chk("mon_blank", 8'(bus1.o_blank),         8'(exp_blank));
      chk("ng_blank",  8'(bus2.o_blank),         8'h00);
      chk("ng_tick",   8'(bus2.o_scanTick),      8'((mn % 4) == 3));
    end
  end

  typedef struct {
    int         n;
    logic [2:0] pos;
    logic       blank;
    logic       tick;
    logic       phase;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    onoff = 1'b0;
    page = 1'b0;
    blink_en = 1'b0;
    mask = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to(inout int cur, input int n);
    while (cur < n) begin
      step();
      cur++;
    end
  endtask

  initial begin
    int cur;

    tbl.push_back('{0,  3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1,  3'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{3,  3'd0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{4,  3'd1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{5,  3'd1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{8,  3'd2, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{11, 3'd2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{12, 3'd3, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{16, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{17, 3'd0, 1'b0, 1'b0, 1'b1});

    // Reset-release table.
    @(negedge clk);
    do_reset();
    cur = 0;
    foreach (tbl[i]) begin
      run_to(cur, tbl[i].n);
      chk($sformatf("tbl%0d_pos", i),   8'(bus1.o_digitPosition), 8'(tbl[i].pos));
      chk($sformatf("tbl%0d_blank", i), 8'(bus1.o_blank),         8'(tbl[i].blank));
      chk($sformatf("tbl%0d_tick", i),  8'(bus1.o_scanTick),      8'(tbl[i].tick));
      chk($sformatf("tbl%0d_phase", i), 8'(bus1.o_blinkPhase),    8'(tbl[i].phase));
    end

    // Page request mid-frame only takes effect at the frame boundary.
    do_reset();
    cur = 0;
    run_to(cur, 5);  page = 1'b1;
    run_to(cur, 8);  chk("page_p8",  8'(bus1.o_digitPosition), 8'd2);
    run_to(cur, 15); chk("page_p15", 8'(bus1.o_digitPosition), 8'd3);
    run_to(cur, 16); chk("page_p16", 8'(bus1.o_digitPosition), 8'd4);
    run_to(cur, 17); page = 1'b0;
    run_to(cur, 20); chk("page_p20", 8'(bus1.o_digitPosition), 8'd5);
    run_to(cur, 24); chk("page_p24", 8'(bus1.o_digitPosition), 8'd6);
    run_to(cur, 31); chk("page_p31", 8'(bus1.o_digitPosition), 8'd7);
    run_to(cur, 32); chk("page_p32", 8'(bus1.o_digitPosition), 8'd0);

    // Blink on slot 2 only.
    do_reset();
    cur = 0;
    blink_en = 1'b1;
    mask = 4'b0100;
    run_to(cur, 1);  chk("blk_n1",  8'(bus1.o_blank), 8'd0);
    run_to(cur, 8);  chk("blk_n8",  8'(bus1.o_blank), 8'd1);
    run_to(cur, 9);  chk("blk_n9",  8'(bus1.o_blank), 8'd1);
    run_to(cur, 13); chk("blk_n13", 8'(bus1.o_blank), 8'd0);
    run_to(cur, 16); chk("blk_ph16", 8'(bus1.o_blinkPhase), 8'd1);
    run_to(cur, 17); chk("blk_n17", 8'(bus1.o_blank), 8'd0);
    run_to(cur, 24); chk("blk_ph24", 8'(bus1.o_blinkPhase), 8'd0);
    run_to(cur, 25); chk("blk_n25", 8'(bus1.o_blank), 8'd1);

    // Display off for 20 clocks: blanked but scanning continues.
    do_reset();
    cur = 0;
    run_to(cur, 6);
    onoff = 1'b1;
    repeat (20) begin
      step();
      cur++;
      chk("off_blank", 8'(bus1.o_blank), 8'd1);
    end
    chk("off_pos26", 8'(bus1.o_digitPosition), 8'd2);
    onoff = 1'b0;
    run_to(cur, 29);
    chk("on_pos29",   8'(bus1.o_digitPosition), 8'd3);
    chk("on_blank29", 8'(bus1.o_blank), 8'd0);
    run_to(cur, 31);
    chk("on_tick31",  8'(bus1.o_scanTick), 8'd1);

    // One-clock reset pulse at slot 2, prescaler 2.
    do_reset();
    cur = 0;
    run_to(cur, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rp_pos",   8'(bus1.o_digitPosition), 8'd0);
    chk("rp_tick",  8'(bus1.o_scanTick), 8'd0);
    chk("rp_phase", 8'(bus1.o_blinkPhase), 8'd1);
    chk("rp_blank", 8'(bus1.o_blank), 8'd1);
    cur = 0;
    run_to(cur, 2); chk("rp_tick2", 8'(bus1.o_scanTick), 8'd0);
    run_to(cur, 3); chk("rp_tick3", 8'(bus1.o_scanTick), 8'd1);
    run_to(cur, 4); chk("rp_pos4",  8'(bus1.o_digitPosition), 8'd1);

    // Randomised inputs with occasional resets; the monitor compares against the model.
    repeat (1500) begin
      step();
      rst      = ($urandom_range(0, 99) == 0);
      onoff    = ($urandom_range(0, 7) == 0);
      page     = $urandom_range(0, 1) == 1;
      blink_en = $urandom_range(0, 1) == 1;
      mask     = 4'($urandom_range(0, 15));
      page2    = $urandom_range(0, 1) == 1;
      mask2    = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
